// File: rtl/gen_buffer_scan_ctrl.sv
// -----------------------------------------------------------------------------
// gen_buffer_scan_ctrl
//
// Read-side sequencer for the single-port history buffer. A start pulse
// latches the buffer fullness N and walks every stored element through the
// buffer's indexed read port. Each element is returned on a valid/ready
// stream, and o_last marks the final one. Reads give way to upstream adds,
// because the buffer accepts only one request per cycle.
//
// Optional feature macro: GEN_BUFFER_SCAN_NEWEST_FIRST_EN
//   undefined : the i-th read uses index i (oldest first)
//   defined   : the i-th read uses index N-1-i (newest first)
//
// Ports
//   clk, rstn     clock, asynchronous active-low reset
//   sw_rst        synchronous reset, same effect as rstn
//   start         scan request pulse (ignored while busy)
//   buf_fullness  number of elements stored in the buffer
//   buf_add_req   upstream add to the buffer this cycle (has priority)
//   buf_o_data    buffer read data, valid 1 clk after rd_elem_req
//   rd_elem_req   buffer read request
//   rd_elem_idx   buffer read index
//   o_valid, o_data, o_last, i_ready   output element stream
//   busy          scan in progress
//   done          one-cycle pulse when the last element has been accepted
// -----------------------------------------------------------------------------
module gen_buffer_scan_ctrl #(
  parameter  int DATA_W      = 8,
  parameter  int DEPTH       = 100,
  parameter  int SIM_DLY     = 1,
  localparam int DEPTH_W     = $clog2(DEPTH + 1),
  localparam int DEPTH_IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   sw_rst,
  input  logic                   start,
  input  logic [DEPTH_W-1:0]     buf_fullness,
  input  logic                   buf_add_req,
  input  logic [DATA_W-1:0]      buf_o_data,
  output logic                   rd_elem_req,
  output logic [DEPTH_IDX_W-1:0] rd_elem_idx,
  output logic                   o_valid,
  output logic [DATA_W-1:0]      o_data,
  output logic                   o_last,
  input  logic                   i_ready,
  output logic                   busy,
  output logic                   done
);

  // SIM_DLY only models register delay in behavioural simulation. The RTL
  // itself carries no delays, so here the value is only sanity-checked.
  if (SIM_DLY < 0) begin : g_sim_dly_check
    $error("SIM_DLY must be non-negative");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t            state;
  logic [DEPTH_W-1:0] n_q;        // elements in this scan
  logic [DEPTH_W-1:0] k_q;        // reads issued
  logic [DEPTH_W-1:0] a_q;        // elements accepted downstream
  logic               done_q;

  // Read return tracking and the 2-entry output FIFO
  logic               rd_vld_p1;  // buf_o_data holds a returning element
  logic [DATA_W-1:0]  fifo_mem [2];
  logic               fifo_wp;
  logic               fifo_rp;
  logic [1:0]         fifo_cnt;

  logic [1:0]         occ;
  logic               head_vld;
  logic [DATA_W-1:0]  head_data;
  logic               pop;
  logic               pop_fifo;
  logic               push;
  logic               last_acc;
  logic [DEPTH_IDX_W-1:0] idx_nxt;

  // ---- p0: read issue ------------------------------------------------------
  // The returning element counts against the FIFO, so at most two elements
  // are ever buffered or in flight. That reservation is why the FIFO cannot
  // overflow.
  assign occ = fifo_cnt + {1'b0, rd_vld_p1};

  assign rd_elem_req = (state == SCAN) && (k_q < n_q) && !buf_add_req &&
                       (occ < 2'd2) && !sw_rst;

  // Only the low index bits matter, so the subtraction is done modulo the
  // index width.
`ifdef GEN_BUFFER_SCAN_NEWEST_FIRST_EN
  assign idx_nxt = n_q[DEPTH_IDX_W-1:0] - DEPTH_IDX_W'(1) - k_q[DEPTH_IDX_W-1:0];
`else
  assign idx_nxt = k_q[DEPTH_IDX_W-1:0];
`endif

  assign rd_elem_idx = rd_elem_req ? idx_nxt : '0;

  // ---- p1: read return / output head -----------------------------------------
  // When the FIFO is empty, the returning element bypasses it straight to the
  // output. This lets the first element appear one cycle after its read.
  assign head_vld  = (fifo_cnt != 2'd0) || rd_vld_p1;
  assign head_data = (fifo_cnt != 2'd0) ? fifo_mem[fifo_rp] : buf_o_data;
  assign pop       = head_vld && i_ready;
  assign pop_fifo  = pop && (fifo_cnt != 2'd0);
  assign push      = rd_vld_p1 && !((fifo_cnt == 2'd0) && pop);
  assign last_acc  = pop && o_last;

  assign o_valid = head_vld;
  assign o_data  = head_vld ? head_data : '0;
  assign o_last  = head_vld && (a_q == n_q - DEPTH_W'(1));
  assign busy    = (state != IDLE);
  assign done    = done_q;

  // Control state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      n_q       <= '0;
      k_q       <= '0;
      a_q       <= '0;
      done_q    <= 1'b0;
      rd_vld_p1 <= 1'b0;
      fifo_wp   <= 1'b0;
      fifo_rp   <= 1'b0;
      fifo_cnt  <= 2'd0;
    end else if (sw_rst) begin
      state     <= IDLE;
      n_q       <= '0;
      k_q       <= '0;
      a_q       <= '0;
      done_q    <= 1'b0;
      rd_vld_p1 <= 1'b0;
      fifo_wp   <= 1'b0;
      fifo_rp   <= 1'b0;
      fifo_cnt  <= 2'd0;
    end else begin
      done_q    <= 1'b0;
      rd_vld_p1 <= rd_elem_req;

      if (push)     fifo_wp <= ~fifo_wp;
      if (pop_fifo) fifo_rp <= ~fifo_rp;
      unique case ({push, pop_fifo})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      if (pop) a_q <= a_q + DEPTH_W'(1);

      unique case (state)
        IDLE: begin
          if (start) begin
            n_q <= buf_fullness;
            k_q <= '0;
            a_q <= '0;
            if (buf_fullness == '0) done_q <= 1'b1;
            else                    state  <= SCAN;
          end
        end
        SCAN: begin
          if (rd_elem_req) begin
            k_q <= k_q + DEPTH_W'(1);
            if (k_q + DEPTH_W'(1) == n_q) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_acc) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- p2: FIFO storage (data only, no reset needed) ------------------------
  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wp] <= buf_o_data;
  end

endmodule

// File: doc/gen_buffer_scan_ctrl.md
# gen_buffer_scan_ctrl

Read-side sequencer placed directly downstream of the single-port-memory history buffer. On a start pulse it reads every stored element, oldest to newest, through the buffer's indexed read port. It returns each element on a valid/ready output stream with backpressure and marks the last element. It arbitrates read slots against upstream element additions, because the buffer accepts only one request per cycle.

## Interface
Parameters:
- DATA_W, 8, element width; must match the buffer.
- DEPTH, 100, buffer capacity; must match the buffer.
- SIM_DLY, 1, simulation delay on register updates.
- DEPTH_W, $clog2(DEPTH+1), count width (local, do not override).
- DEPTH_IDX_W, $clog2(DEPTH), index width (local, do not override).

Ports (one clock; reset is asynchronous and active-low):
- clk, in, 1, clock.
- rstn, in, 1, asynchronous active-low reset.
- sw_rst, in, 1, synchronous reset with the same effect as rstn.
- start, in, 1, scan request pulse; ignored while busy.
- buf_fullness, in, DEPTH_W, buffer fullness.
- buf_add_req, in, 1, upstream add to the buffer this cycle.
- buf_o_data, in, DATA_W, buffer read data, valid 1 clk after a read request.
- rd_elem_req, out, 1, buffer read request.
- rd_elem_idx, out, DEPTH_IDX_W, buffer read index.
- o_valid, out, 1, output element valid.
- o_data, out, DATA_W, output element.
- o_last, out, 1, qualifies the final element of the scan.
- i_ready, in, 1, downstream accepts the element when o_valid and i_ready are both high.
- busy, out, 1, scan in progress.
- done, out, 1, one-cycle pulse at scan completion.

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE, start=1:
  - Latch N = buf_fullness, clear issue count k and accept count a.
  - N=0: pulse done next cycle and stay in IDLE.
  - Otherwise go to SCAN.
- SCAN issues a read when all three hold: k<N, buf_add_req=0, and (out-FIFO occupancy + reads in flight) < 2.
  - rd_elem_idx = k (order without the macro; see Configuration), then k increments.
  - When k reaches N, go to DRAIN.
- Read returns:
  - Data captured the cycle after the request goes into a 2-entry output FIFO.
  - The FIFO never overflows, because the issue rule above reserves the slot.
- Output:
  - o_data/o_valid come from the FIFO head.
  - o_last = 1 when the head is element N-1 of the scan.
- DRAIN: when the element with o_last is accepted, pulse done in the following cycle and return to IDLE.
- busy = 1 in SCAN and DRAIN.
- rd_elem_req is never asserted in the same cycle as buf_add_req.
- An add during a scan when the buffer is full shifts the oldest entry. Reads use current buffer indexing. Upstream uses busy to hold off adds when a consistent snapshot is required.
- sw_rst or rstn in mid-scan: return to IDLE immediately, flush the FIFO, and discard the in-flight read. No done pulse.
- Counters k and a are DEPTH_W wide; rd_elem_idx is the low DEPTH_IDX_W bits of the index.

## Timing
- Reset values: rd_elem_req=0, rd_elem_idx=0, o_valid=0, o_data=0, o_last=0, busy=0, done=0.
- start sampled at cycle t: busy=1 at t+1; first rd_elem_req at t+1 (if buf_add_req=0).
- First o_valid at t+2.
- With i_ready held high and no adds: one element per clk; last element at t+N+1; done at t+N+2.
- Each buf_add_req cycle during SCAN delays the remaining stream by 1 clk.
- i_ready low: at most 2 elements buffered; issue stalls until a slot frees.
- start asserted while busy has no effect.

## Configuration
- Macro GEN_BUFFER_SCAN_NEWEST_FIRST_EN.
- Undefined: the i-th issued read uses index i (oldest first).
- Defined: the i-th issued read uses index N-1-i (newest first).
- o_last, done and counts behave identically in both builds.

## Test plan
- N=4 (elements A,B,C,D), i_ready=1, no adds -> rd_elem_idx 0,1,2,3 on consecutive clks. Outputs A,B,C,D at t+2..t+5, o_last with D, done at t+6. With the macro defined: idx 3,2,1,0 and outputs D,C,B,A.
- buf_fullness=0 with start -> no rd_elem_req, no o_valid, done exactly 1 clk later, busy stays 0.
- N=5 with i_ready held low for 6 clks after start -> exactly 2 reads issued, o_valid held with data A stable. Release i_ready -> remaining 3 reads issued; all 5 elements delivered in order with no loss or duplicates.
- N=3 with buf_add_req high on the second issue cycle -> rd_elem_req low that cycle and never coincident with buf_add_req; the stream completes 1 clk later than the no-add case.
- sw_rst pulse after 2 of 6 elements delivered -> next cycle busy=0, o_valid=0, no done pulse. A new start then scans from index 0.
- start asserted repeatedly during a scan -> ignored: N unchanged, single done pulse.
